// File: rtl/scan_seg_multi_if.sv
// Display-register side of the multiplexed 7-segment driver.
// The master drives the value and display options; the slave returns the scan outputs.
interface scan_seg_multi_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] seg_data;
  logic                  mode;
  logic                  blank_lz;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blink_mask;
  logic [N_DIGITS-1:0]   seg_en;
  logic [7:0]            seg_out0;
  logic [7:0]            seg_out1;

  modport master (
    output seg_data, mode, blank_lz, dp_mask, blink_mask,
    input  seg_en, seg_out0, seg_out1
  );

  modport slave (
    input  seg_data, mode, blank_lz, dp_mask, blink_mask,
    output seg_en, seg_out0, seg_out1
  );
endinterface

// File: rtl/scan_seg_multi.sv
// Time-multiplexed 7-segment driver: hex or decimal (sequential double-dabble) display
// with leading-zero blanking, per-digit decimal points and per-digit blink.
module scan_seg_multi #(
  parameter int unsigned N_DIGITS   = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLINK_HALF = 50000000
) (
  input  logic           clk,
  input  logic           rst,
  scan_seg_multi_if.slave bus
);
  localparam int unsigned BIN_W = 4 * N_DIGITS;
  localparam int unsigned BCD_W = 4 * (N_DIGITS + 2);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned SC_W  = $clog2(SCAN_DIV);
  localparam int unsigned BK_W  = $clog2(BLINK_HALF);
  localparam int unsigned SH_W  = $clog2(BIN_W);
  localparam int unsigned HALF  = N_DIGITS / 2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  conv_state_t       state_q, state_d;
  logic [SC_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [BK_W-1:0]   blink_cnt;
  logic              blink_off;
  logic [BIN_W-1:0]  bin_sr;
  logic [BIN_W-1:0]  last_val;
  logic [BCD_W-1:0]  bcd_sh;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  logic [SH_W-1:0]   shift_cnt;
  logic [BIN_W-1:0]  disp_bcd;
  logic              disp_ovf;
  logic              dec_valid;
  logic              need_conv;
  logic              load_en, shift_en, done_en;
  logic              dec_on, ovf_on, upper_nz, blank;
  logic [BIN_W-1:0]  shown;
  logic [3:0]        nib;
  logic [7:0]        glyph;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 8'hFC;
      4'h1: seg7 = 8'h60;
      4'h2: seg7 = 8'hDA;
      4'h3: seg7 = 8'hF2;
      4'h4: seg7 = 8'h66;
      4'h5: seg7 = 8'hB6;
      4'h6: seg7 = 8'hBE;
      4'h7: seg7 = 8'hE0;
      4'h8: seg7 = 8'hFE;
      4'h9: seg7 = 8'hF6;
      4'hA: seg7 = 8'hEE;
      4'hB: seg7 = 8'h3E;
      4'hC: seg7 = 8'h9C;
      4'hD: seg7 = 8'h7A;
      4'hE: seg7 = 8'h9E;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BK_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      IDLE:  if (bus.mode && (need_conv || bus.seg_data != last_val)) state_d = LOAD;
      LOAD:  begin
        load_en = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (shift_cnt == SH_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE:  begin
        done_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every BCD digit, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int unsigned i = 0; i < N_DIGITS + 2; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | BCD_W'(bin_sr[BIN_W-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sr    <= '0;
      last_val  <= '0;
      bcd_sh    <= '0;
      shift_cnt <= '0;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
      dec_valid <= 1'b0;
      need_conv <= 1'b1;
    end else begin
      if (load_en) begin
        bin_sr    <= bus.seg_data;
        last_val  <= bus.seg_data;
        bcd_sh    <= '0;
        shift_cnt <= '0;
        need_conv <= 1'b0;
      end
      if (shift_en) begin
        bcd_sh    <= bcd_next;
        bin_sr    <= bin_sr << 1;
        shift_cnt <= shift_cnt + SH_W'(1);
      end
      if (done_en) begin
        disp_bcd <= bcd_sh[BIN_W-1:0];
        disp_ovf <= |bcd_sh[BCD_W-1:BIN_W];
      end
      // Leaving decimal mode invalidates the result so re-entry shows hex until a fresh DONE.
      if (!bus.mode) begin
        need_conv <= 1'b1;
        dec_valid <= 1'b0;
      end else if (done_en) begin
        dec_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    dec_on   = bus.mode && dec_valid;
    shown    = dec_on ? disp_bcd : bus.seg_data;
    ovf_on   = dec_on && disp_ovf;
    nib      = shown[4*idx +: 4];
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j >= 32'(idx) && shown[4*j +: 4] != 4'h0) upper_nz = 1'b1;
    end
    blank = bus.blank_lz && !ovf_on && (idx != '0) && !upper_nz;
    if (ovf_on)     glyph = 8'h02;
    else if (blank) glyph = 8'h00;
    else            glyph = seg7(nib);
    glyph = glyph | {7'b0, bus.dp_mask[idx]};
    if (blink_off && bus.blink_mask[idx]) glyph = 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.seg_en   <= '0;
      bus.seg_out0 <= '0;
      bus.seg_out1 <= '0;
    end else begin
      bus.seg_en <= {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
      if (idx >= IDX_W'(HALF)) begin
        bus.seg_out0 <= glyph;
        bus.seg_out1 <= 8'h00;
      end else begin
        bus.seg_out0 <= 8'h00;
        bus.seg_out1 <= glyph;
      end
    end
  end
endmodule

// File: tb/tb_scan_seg_multi.sv
// Scoreboard bench for scan_seg_multi: stimulus queues expected digit frames,
// a negedge monitor compares each new digit presentation against the queue.
module tb_scan_seg_multi;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  scan_seg_multi_if #(.N_DIGITS(N)) bus ();

  scan_seg_multi #(.N_DIGITS(N), .SCAN_DIV(4), .BLINK_HALF(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] o0;
    logic [7:0] o1;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [63:0] G_12345678 =
    {8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int unsigned d, input logic [7:0] g);
    exp_t e;
    e.en = 8'(1 << d);
    e.o0 = (d >= N/2) ? g : 8'h00;
    e.o1 = (d <  N/2) ? g : 8'h00;
    return e;
  endfunction

  task automatic push_scan(input logic [63:0] gl);
    for (int unsigned d = 0; d < N; d++) sb_q.push_back(mk(d, gl[8*d +: 8]));
  endtask

  // Returns just after the edge that follows the first sample of a fresh digit-7 presentation.
  task automatic sync_last(input string tag);
    logic was;
    logic found;
    was   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (bus.seg_en == 8'h80 && !was) found = 1'b1;
      was = (bus.seg_en == 8'h80);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sync: seg_en=%02h never reached 80", tag, bus.seg_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: got %0d digits unpresented expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  logic [7:0] prev_en = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (bus.seg_en != prev_en && bus.seg_en != 8'h00 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check8("seg_en",   bus.seg_en,   e.en);
      check8($sformatf("seg_out0[en=%02h]", e.en), bus.seg_out0, e.o0);
      check8($sformatf("seg_out1[en=%02h]", e.en), bus.seg_out1, e.o1);
    end
    prev_en = bus.seg_en;
  end

  initial begin
    int cur;
    bus.seg_data   = 32'h0000_0004;
    bus.mode       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.dp_mask    = 8'h00;
    bus.blink_mask = 8'h00;

    // Reset and scan start
    repeat (3) @(posedge clk);
    #1;
    check8("rst_seg_en",   bus.seg_en,   8'h00);
    check8("rst_seg_out0", bus.seg_out0, 8'h00);
    check8("rst_seg_out1", bus.seg_out1, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("first_seg_en", bus.seg_en, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    check8("hold_seg_en", bus.seg_en, 8'h01);
    @(posedge clk);
    #1;
    check8("second_seg_en", bus.seg_en, 8'h02);

    // Hex, no blanking, then blanking (first frame also covers 80 -> 01 wrap)
    sync_last("hex");
    push_scan({{7{8'hFC}}, 8'h66});
    wait_empty("hex");
    bus.blank_lz = 1'b1;
    sync_last("hex_lz");
    push_scan({{7{8'h00}}, 8'h66});
    wait_empty("hex_lz");

    // Decimal overflow, then largest in-range value
    bus.blank_lz = 1'b0;
    bus.mode     = 1'b1;
    bus.seg_data = 32'd100000000;
    repeat (45) @(posedge clk);
    sync_last("ovf");
    push_scan({8{8'h02}});
    wait_empty("ovf");
    bus.seg_data = 32'd99999999;
    repeat (45) @(posedge clk);
    sync_last("max");
    push_scan({8{8'hF6}});
    wait_empty("max");

    // Input changes mid-SHIFT: old capture must land first, then the new value
    bus.seg_data = 32'd12345678;
    repeat (10) @(posedge clk);
    #1;
    bus.seg_data = 32'd9;
    repeat (28) @(posedge clk);
    #1;
    cur = -1;
    for (int i = 0; i < 8; i++) if (bus.seg_en[i]) cur = i;
    if (cur < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL midshift_pos: got seg_en=%02h expected one-hot", bus.seg_en);
    end else begin
      for (int k = 1; k <= 7; k++) begin
        int unsigned d;
        d = 32'((cur + k) % 8);
        sb_q.push_back(mk(d, G_12345678[8*d +: 8]));
      end
    end
    wait_empty("midshift_old");
    repeat (40) @(posedge clk);
    sync_last("midshift_new");
    push_scan({{7{8'hFC}}, 8'hF6});
    wait_empty("midshift_new");

    // Asynchronous reset during SHIFT, then rerun
    bus.seg_data = 32'd12345678;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check8("async_seg_en",   bus.seg_en,   8'h00);
    check8("async_seg_out0", bus.seg_out0, 8'h00);
    check8("async_seg_out1", bus.seg_out1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (45) @(posedge clk);
    sync_last("rerun");
    push_scan(G_12345678);
    wait_empty("rerun");

    // Blink + dp on digit 0; phase aligned by a fresh reset (32-cycle scan, 64-cycle half period)
    bus.mode       = 1'b0;
    bus.seg_data   = 32'h0;
    bus.dp_mask    = 8'h01;
    bus.blink_mask = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_scan({{7{8'hFC}}, 8'hFD});
    push_scan({{7{8'hFC}}, 8'hFD});
    push_scan({{7{8'hFC}}, 8'h00});
    push_scan({{7{8'hFC}}, 8'h00});
    push_scan({{7{8'hFC}}, 8'hFD});
    wait_empty("blink");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
